// File: rtl/ravenoc_axi_pkt_gen.sv
// AXI4 INCR write-burst generator: N bursts to one address, data = seed + run beat index.
// Latency: awvalid/busy_o one cycle after start_i; done_o one cycle after the last B handshake.
// Backpressure: one burst outstanding; every valid and its payload hold until the handshake. Option: RAVENOC_PKT_GEN_STATS_EN.
module ravenoc_axi_pkt_gen #(
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ALEN_W = 8
) (
  input  logic                    clk_axi,
  input  logic                    arst_axi,
  input  logic                    start_i,
  input  logic [AXI_ADDR_W-1:0]   dest_addr_i,
  input  logic [AXI_ALEN_W-1:0]   burst_len_i,
  input  logic [15:0]             num_pkts_i,
  input  logic [AXI_DATA_W-1:0]   seed_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             pkt_cnt_o,
  output logic [15:0]             err_cnt_o,
  output logic [31:0]             lat_max_o,
  output logic                    awid,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [AXI_ALEN_W-1:0]   awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam logic [2:0] AWSIZE = 3'($clog2(AXI_DATA_W/8));

  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [AXI_ALEN_W-1:0]   len_q;
  logic [AXI_ALEN_W-1:0]   beat_q;
  logic [15:0]             num_q;
  logic [15:0]             pkt_q;
  logic [15:0]             err_q;
  logic [AXI_DATA_W-1:0]   data_q;
  logic                    start_acc;
  logic                    aw_hs, w_hs, b_hs, last_beat;
  logic                    unused_bid;

  assign unused_bid = bid;
  assign start_acc  = (state_q == ST_IDLE) && start_i;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid && bready;
  assign last_beat  = (beat_q == len_q);

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = (num_pkts_i == 16'd0) ? ST_DONE : ST_AW;
      ST_AW:   if (awready) state_d = ST_W;
      ST_W:    if (wready && last_beat) state_d = ST_B;
      ST_B:    if (bvalid) state_d = (pkt_q + 16'd1 == num_q) ? ST_DONE : ST_AW;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Payloads are only driven in their own phase so reset and idle present all-zero outputs.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    done_o  = (state_q == ST_DONE);
    awid    = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    awsize  = 3'd0;
    awburst = 2'b00;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (state_q)
      ST_AW: begin
        awvalid = 1'b1;
        awaddr  = addr_q;
        awlen   = len_q;
        awsize  = AWSIZE;
        awburst = 2'b01;
      end
      ST_W: begin
        wvalid = 1'b1;
        wdata  = data_q;
        wstrb  = '1;
        wlast  = last_beat;
      end
      ST_B:    bready = 1'b1;
      default: ;
    endcase
  end

  // data_q is the run-global beat counter; it is deliberately not cleared between bursts.
  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      addr_q <= '0;
      len_q  <= '0;
      num_q  <= '0;
      data_q <= '0;
      beat_q <= '0;
      pkt_q  <= '0;
      err_q  <= '0;
    end else begin
      if (start_acc) begin
        addr_q <= dest_addr_i;
        len_q  <= burst_len_i;
        num_q  <= num_pkts_i;
        data_q <= seed_i;
        pkt_q  <= '0;
        err_q  <= '0;
      end
      if (aw_hs) beat_q <= '0;
      if (w_hs) begin
        beat_q <= beat_q + AXI_ALEN_W'(1);
        data_q <= data_q + AXI_DATA_W'(1);
      end
      if (b_hs) begin
        pkt_q <= pkt_q + 16'd1;
        if (bresp != 2'b00 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_q;
  assign err_cnt_o = err_q;

`ifdef RAVENOC_PKT_GEN_STATS_EN
  logic [31:0] lat_cnt_q, lat_max_q;
  logic        enter_aw;

  assign enter_aw = (state_d == ST_AW) && (state_q != ST_AW);

  // lat_cnt_q counts inclusively: 1 on the first awvalid cycle, burst length in cycles at B.
  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      lat_cnt_q <= '0;
      lat_max_q <= '0;
    end else begin
      if (start_acc) lat_max_q <= '0;
      if (enter_aw)
        lat_cnt_q <= 32'd1;
      else if ((state_q == ST_AW || state_q == ST_W || state_q == ST_B) && lat_cnt_q != 32'hFFFF_FFFF)
        lat_cnt_q <= lat_cnt_q + 32'd1;
      if (b_hs && lat_cnt_q > lat_max_q) lat_max_q <= lat_cnt_q;
    end
  end

  assign lat_max_o = lat_max_q;
`else
  assign lat_max_o = '0;
`endif

endmodule

// File: tb/tb_ravenoc_axi_pkt_gen.sv
// Randomised bench for ravenoc_axi_pkt_gen: a phase/queue model of the run checked every cycle.
module tb_ravenoc_axi_pkt_gen;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int P_IDLE = 0, P_AW = 1, P_W = 2, P_B = 3, P_DONE = 4;

  logic            clk_axi = 1'b0;
  logic            arst_axi = 1'b0;
  logic            start_i = 1'b0;
  logic [AW-1:0]   dest_addr_i = '0;
  logic [LW-1:0]   burst_len_i = '0;
  logic [15:0]     num_pkts_i = '0;
  logic [DW-1:0]   seed_i = '0;
  logic            busy_o, done_o;
  logic [15:0]     pkt_cnt_o, err_cnt_o;
  logic [31:0]     lat_max_o;
  logic            awid;
  logic [AW-1:0]   awaddr;
  logic [LW-1:0]   awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready = 1'b0;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid;
  logic            wready = 1'b0;
  logic            bid = 1'b0;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid = 1'b0;
  logic            bready;

  ravenoc_axi_pkt_gen #(.AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ALEN_W(LW)) dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi), .start_i(start_i), .dest_addr_i(dest_addr_i),
    .burst_len_i(burst_len_i), .num_pkts_i(num_pkts_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o),
    .lat_max_o(lat_max_o), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk_axi = ~clk_axi;

  int checks = 0;
  int errors = 0;

  // Model of the run: phase, latched parameters, beats/responses seen so far.
  int            ph = P_IDLE;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_len = '0;
  logic [15:0]   m_num = '0;
  logic [DW-1:0] m_seed = '0;
  int            beat_g = 0;
  logic [15:0]   m_pkt = '0;
  logic [15:0]   m_err = '0;
  logic [31:0]   m_lat = '0;
  int            cyc = 0;
  int            aw_start = 0;
  int            aw_hs_cnt = 0;
  int            start_cyc = 0;
  int            done_cyc = 0;
  logic [DW-1:0] wq[$];

  // Stimulus controls
  bit            req_start = 0;
  bit            poke = 0;
  bit            rand_bresp = 0;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len;
  logic [15:0]   r_num;
  logic [DW-1:0] r_seed;
  int            aw_max = 0, w_max = 0, b_max = 0;
  int            aw_wait = 0, w_wait = 0, b_wait = 0;
  int            b_ovr [16];
  logic [1:0]    bresp_tab [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int rnd(input int mx);
    return (mx <= 0) ? 0 : int'($urandom_range(0, mx));
  endfunction

  function automatic int pick_b(input int k);
    return (b_ovr[k % 16] >= 0) ? b_ovr[k % 16] : rnd(b_max);
  endfunction

  task automatic cycle();
    logic [DW-1:0] exp_wd;
    logic aw_h, w_h, b_h;
    int lat;
    @(negedge clk_axi);
    exp_wd = m_seed + DW'(beat_g);
    chk("busy", busy_o, ph != P_IDLE);
    chk("done", done_o, ph == P_DONE);
    chk("awvalid", awvalid, ph == P_AW);
    chk("wvalid", wvalid, ph == P_W);
    chk("bready", bready, ph == P_B);
    chk("pkt_cnt", pkt_cnt_o, m_pkt);
    chk("err_cnt", err_cnt_o, m_err);
`ifdef RAVENOC_PKT_GEN_STATS_EN
    chk("lat_max", lat_max_o, m_lat);
`else
    chk("lat_max", lat_max_o, 0);
`endif
    if (ph == P_AW) begin
      chk("awaddr", awaddr, m_addr);
      chk("awlen", awlen, m_len);
      chk("awid", awid, 0);
      chk("awsize", awsize, 2);
      chk("awburst", awburst, 1);
    end
    if (ph == P_W) begin
      chk("wdata", wdata, exp_wd);
      chk("wstrb", wstrb, 4'hF);
      chk("wlast", wlast, (beat_g % (int'(m_len) + 1)) == int'(m_len));
    end
    // Drive inputs for the next rising edge
    start_i = 1'b0;
    if (req_start && ph == P_IDLE) begin
      start_i = 1'b1; dest_addr_i = r_addr; burst_len_i = r_len;
      num_pkts_i = r_num; seed_i = r_seed; req_start = 0; start_cyc = cyc;
    end else if (poke && ph != P_IDLE && rnd(3) == 0) begin
      start_i = 1'b1; dest_addr_i = $urandom; burst_len_i = LW'($urandom);
      num_pkts_i = 16'($urandom); seed_i = $urandom;
    end
    bid = 1'($urandom_range(0, 1));
    awready = awvalid && (aw_wait == 0);
    if (awvalid && aw_wait > 0) aw_wait--;
    wready = wvalid && (w_wait == 0);
    if (wvalid && w_wait > 0) w_wait--;
    bvalid = bready && (b_wait == 0);
    if (bready && b_wait > 0) b_wait--;
    bresp = rand_bresp ? 2'($urandom_range(0, 3)) : bresp_tab[int'(m_pkt) % 16];
    aw_h = awvalid && awready;
    w_h  = wvalid && wready;
    b_h  = bvalid && bready;
    // Advance the model to the state after that edge
    case (ph)
      P_IDLE: if (start_i) begin
        m_addr = dest_addr_i; m_len = burst_len_i; m_num = num_pkts_i; m_seed = seed_i;
        m_pkt = '0; m_err = '0; m_lat = '0; beat_g = 0; aw_hs_cnt = 0; wq.delete();
        ph = (num_pkts_i == 16'd0) ? P_DONE : P_AW;
        aw_start = cyc + 1; aw_wait = rnd(aw_max); w_wait = rnd(w_max); b_wait = pick_b(0);
      end
      P_AW: if (aw_h) begin aw_hs_cnt++; ph = P_W; aw_wait = rnd(aw_max); end
      P_W: if (w_h) begin
        wq.push_back(wdata);
        if ((beat_g % (int'(m_len) + 1)) == int'(m_len)) ph = P_B;
        beat_g++; w_wait = rnd(w_max);
      end
      P_B: if (b_h) begin
        if (bresp != 2'b00 && m_err != 16'hFFFF) m_err++;
        lat = cyc - aw_start + 1;
        if (32'(lat) > m_lat) m_lat = 32'(lat);
        m_pkt++;
        if (m_pkt == m_num) ph = P_DONE;
        else begin ph = P_AW; aw_start = cyc + 1; b_wait = pick_b(int'(m_pkt)); end
      end
      P_DONE: begin ph = P_IDLE; done_cyc = cyc; end
      default: ph = P_IDLE;
    endcase
    cyc++;
  endtask

  task automatic run(input logic [AW-1:0] a, input logic [LW-1:0] l,
                     input logic [15:0] n, input logic [DW-1:0] s);
    int k;
    r_addr = a; r_len = l; r_num = n; r_seed = s; req_start = 1;
    k = 0;
    while (req_start && k < 50) begin cycle(); k++; end
    k = 0;
    while (ph != P_IDLE && k < 20000) begin cycle(); k++; end
    chk("run_timeout", ph, P_IDLE);
    cycle();
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin b_ovr[i] = -1; bresp_tab[i] = 2'b00; end
    aw_max = 0; w_max = 0; b_max = 0; poke = 0; rand_bresp = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] exp_wrap [6];
    exp_wrap = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};
    clear_cfg();

    // Reset state
    repeat (3) cycle();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_awsize", awsize, 0);
    arst_axi = 1'b1;
    repeat (2) cycle();

    // Single burst
    run(32'h0000_1000, 8'd3, 16'd1, 32'h10);
    chk("single_nbeats", wq.size(), 4);
    for (int i = 0; i < 4; i++) chk("single_wdata", wq[i], 32'h10 + i);
    chk("single_pkt", pkt_cnt_o, 1);
    chk("single_err", err_cnt_o, 0);

    // Multi-packet with data wrap
    run(32'h0000_2040, 8'd1, 16'd3, 32'hFFFF_FFFE);
    chk("wrap_nbeats", wq.size(), 6);
    for (int i = 0; i < 6; i++) chk("wrap_wdata", wq[i], exp_wrap[i]);
    chk("wrap_aw_hs", aw_hs_cnt, 3);
    chk("wrap_pkt", pkt_cnt_o, 3);

    // Error responses
    bresp_tab[1] = 2'b10; bresp_tab[2] = 2'b11;
    run(32'h0000_3000, 8'd2, 16'd4, 32'hA5A5_0000);
    chk("err_cnt_lit", err_cnt_o, 2);
    chk("err_pkt_lit", pkt_cnt_o, 4);
    clear_cfg();

    // Zero packets
    run(32'h0000_4000, 8'd5, 16'd0, 32'h1);
    chk("zero_done_lat", done_cyc - start_cyc, 1);
    chk("zero_aw_hs", aw_hs_cnt, 0);

    // Latency: bvalid held off 10 cycles on burst 2 of 3
    b_ovr[1] = 10;
    run(32'h0000_5000, 8'd1, 16'd3, 32'h100);
`ifdef RAVENOC_PKT_GEN_STATS_EN
    chk("lat_max_lit", lat_max_o, 14);
`else
    chk("lat_max_off", lat_max_o, 0);
`endif
    clear_cfg();

    // Random backpressure, random responses, start_i poked while busy
    for (int r = 0; r < 6; r++) begin
      aw_max = 5; w_max = 5; b_max = 5; poke = 1; rand_bresp = 1;
      r_len = LW'($urandom_range(0, 15));
      r_num = 16'($urandom_range(1, 6));
      run($urandom, r_len, r_num, $urandom);
      chk("rand_nbeats", wq.size(), int'(r_num) * (int'(r_len) + 1));
      chk("rand_aw_hs", aw_hs_cnt, r_num);
    end
    clear_cfg();

    // Reset during W of the second burst
    w_max = 3;
    r_addr = 32'h0000_6000; r_len = 8'd7; r_num = 16'd2; r_seed = 32'h77; req_start = 1;
    k = 0;
    while (!(ph == P_W && m_pkt == 16'd1 && beat_g >= 10) && k < 500) begin cycle(); k++; end
    chk("rstw_reached", pkt_cnt_o, 1);
    #1 arst_axi = 1'b0;
    #1;
    chk("rstw_awvalid", awvalid, 0);
    chk("rstw_wvalid", wvalid, 0);
    chk("rstw_wlast", wlast, 0);
    chk("rstw_wdata", wdata, 0);
    chk("rstw_bready", bready, 0);
    chk("rstw_busy", busy_o, 0);
    chk("rstw_pkt", pkt_cnt_o, 0);
    ph = P_IDLE; m_pkt = '0; m_err = '0; m_lat = '0; req_start = 0;
    repeat (3) cycle();
    arst_axi = 1'b1;
    repeat (2) cycle();
    clear_cfg();

    // Recovery run after reset
    b_max = 2;
    run(32'h0000_7000, 8'd4, 16'd2, 32'h1234);
    chk("post_rst_pkt", pkt_cnt_o, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
